// File: rtl/uart_cmd_wrapper.sv
// uart_cmd_wrapper: copter-side end of the host command link.
// RX deserializes 8N1 bytes and assembles 3-byte frames {cmd, data_hi, data_lo};
// TX serializes a single response byte.
// Optional build macro: FRAME_TIMEOUT_EN. When defined, a partial frame is
// dropped after TIMEOUT_BITS idle bit times and frm_err pulses.
// Handshakes: cmd_rdy stays high until clr_cmd_rdy or byte0 of the next frame.
// cmd/data are stable while cmd_rdy is high. send_resp is a one-cycle strobe
// and is accepted only while TX is idle. resp_sent pulses once per byte.
module uart_cmd_wrapper #(
  parameter int BAUD_DIV     = 2604,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        frm_err,
  output logic [1:0]  rx_state_dbg,
  output logic [1:0]  tx_state_dbg
);

  // The bit counters are 16 bits wide. resp_sent is raised one cycle before
  // the stop bit ends, so a bit must last at least two cycles.
  if (BAUD_DIV < 4 || BAUD_DIV > 65535) begin : g_bad_baud
    $error("uart_cmd_wrapper: BAUD_DIV out of range");
  end
  if (TIMEOUT_BITS < 1) begin : g_bad_timeout
    $error("uart_cmd_wrapper: TIMEOUT_BITS must be positive");
  end

  localparam logic [15:0] BIT_LAST  = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_LOAD  = 2'd1;
  localparam logic [1:0] TX_SHIFT = 2'd2;

  logic        rx_meta, rx_sync, rx_prev;
  logic [1:0]  rx_state;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh;
  logic [1:0]  byte_idx;
  logic [7:0]  sh_cmd, sh_hi;
  logic        gap_expire;

  logic [1:0]  tx_state;
  logic [15:0] tx_cnt;
  logic [3:0]  tx_bit;
  logic [8:0]  tx_sh;

  assign rx_state_dbg = rx_state;
  assign tx_state_dbg = tx_state;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

`ifdef FRAME_TIMEOUT_EN
  localparam logic [31:0] GAP_LIMIT = 32'(TIMEOUT_BITS * BAUD_DIV);
  logic [31:0] gap_cnt;

  assign gap_expire = (gap_cnt == GAP_LIMIT) && (byte_idx != 2'd0) &&
                      (rx_state == RX_IDLE) && rx_sync;

  // Count idle cycles while a frame is partially assembled
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_cnt <= '0;
    end else if (byte_idx == 2'd0 || rx_state != RX_IDLE || !rx_sync || gap_expire) begin
      gap_cnt <= '0;
    end else begin
      gap_cnt <= gap_cnt + 32'd1;
    end
  end
`else
  // A partial frame waits indefinitely for its remaining bytes
  assign gap_expire = 1'b0;
`endif

  // RX byte FSM and frame assembler
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      byte_idx <= '0;
      sh_cmd   <= '0;
      sh_hi    <= '0;
      cmd      <= '0;
      data     <= '0;
      cmd_rdy  <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      frm_err <= 1'b0;
      if (clr_cmd_rdy) cmd_rdy <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_state <= RX_START;
            rx_cnt   <= HALF_LAST;
          end
        end
        RX_START: begin
          if (rx_cnt == 16'd0) begin
            if (rx_sync) begin
              rx_state <= RX_IDLE;   // glitch, not a start bit
            end else begin
              rx_state <= RX_DATA;
              rx_cnt   <= BIT_LAST;
              rx_bit   <= '0;
            end
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == 16'd0) begin
            rx_sh  <= {rx_sync, rx_sh[7:1]};
            rx_cnt <= BIT_LAST;
            rx_bit <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        default: begin
          if (rx_cnt == 16'd0) begin
            rx_state <= RX_IDLE;
            if (!rx_sync) begin
              frm_err  <= 1'b1;
              byte_idx <= 2'd0;
            end else begin
              case (byte_idx)
                2'd0: begin
                  sh_cmd   <= rx_sh;
                  byte_idx <= 2'd1;
                  cmd_rdy  <= 1'b0;
                end
                2'd1: begin
                  sh_hi    <= rx_sh;
                  byte_idx <= 2'd2;
                end
                default: begin
                  cmd      <= sh_cmd;
                  data     <= {sh_hi, rx_sh};
                  cmd_rdy  <= 1'b1;  // overrides a same-cycle clr_cmd_rdy
                  byte_idx <= 2'd0;
                end
              endcase
            end
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
      endcase
      if (gap_expire) begin
        byte_idx <= 2'd0;
        sh_cmd   <= '0;
        sh_hi    <= '0;
        frm_err  <= 1'b1;
      end
    end
  end

  // TX response FSM: start bit, 8 data bits LSB first, stop bit
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state  <= TX_IDLE;
      TX        <= 1'b1;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_sh     <= '1;
      resp_sent <= 1'b0;
    end else begin
      resp_sent <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (send_resp) begin
            tx_sh    <= {1'b1, resp};
            tx_state <= TX_LOAD;
          end
        end
        TX_LOAD: begin
          TX       <= 1'b0;
          tx_cnt   <= BIT_LAST;
          tx_bit   <= '0;
          tx_state <= TX_SHIFT;
        end
        default: begin
          if (tx_cnt == 16'd0) begin
            if (tx_bit == 4'd9) begin
              tx_state <= TX_IDLE;
            end else begin
              TX     <= tx_sh[0];
              tx_sh  <= {1'b1, tx_sh[8:1]};
              tx_bit <= tx_bit + 4'd1;
              tx_cnt <= BIT_LAST;
            end
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
            if (tx_bit == 4'd9 && tx_cnt == 16'd1) resp_sent <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/uart_cmd_wrapper.md
Name: uart_cmd_wrapper

Overview:
Copter-side end of the host command link. It deserializes 19200-baud UART bytes on RX and assembles each 3-byte frame into an 8-bit command plus 16-bit data for the flight command processor. It also serializes the 1-byte response (ACK 0xA5 or status) back to the host on TX. Sits between the RX/TX pins and the command FSM inside the QuadCopter top level.

Parameters:
BAUD_DIV, 2604, clk cycles per bit (50 MHz / 19200).
TIMEOUT_BITS, 32, inter-byte gap limit in bit times; used only with FRAME_TIMEOUT_EN.

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  synchronous, active-high reset
RX  input  1  serial in from host, asynchronous, idle high
TX  output  1  serial out to host, idle high
cmd  output  8  command byte of the last complete frame
data  output  16  data of the last complete frame {byte1, byte2}
cmd_rdy  output  1  complete frame available
clr_cmd_rdy  input  1  consumer acknowledge, clears cmd_rdy
resp  input  8  response byte to send
send_resp  input  1  one-cycle strobe, starts response transmission
resp_sent  output  1  one-cycle pulse when the stop bit of resp completes
frm_err  output  1  one-cycle pulse on a framing error

Behaviour:
- Reset values: TX=1, cmd=0, data=0, cmd_rdy=0, resp_sent=0, frm_err=0. Both FSMs go to IDLE and the byte index goes to 0.
- RX path: RX passes through a 2-flop synchronizer preset to 1. A falling edge in IDLE starts a bit counter at BAUD_DIV/2.
- RX samples: start bit is re-checked at mid-bit; if it is high, return to IDLE (glitch). Then 8 data bits are taken LSB first at BAUD_DIV intervals, then the stop bit.
- RX FSM states: IDLE -> START -> DATA (8 bits) -> STOP -> IDLE.
- Stop bit = 0: pulse frm_err, discard the byte, reset the byte index to 0. cmd_rdy and cmd/data are untouched.
- Frame assembler: byte index 0/1/2. Byte0 goes to a shadow cmd register, byte1 to shadow data[15:8], byte2 to shadow data[7:0].
- On byte2 completion: in the cycle after the stop-bit sample, cmd/data load from the shadows and cmd_rdy=1. The index wraps to 0.
- cmd and data change only at frame completion. They are stable throughout cmd_rdy=1.
- cmd_rdy clears on clr_cmd_rdy, or when byte0 of a new frame completes.
- Simultaneous clr_cmd_rdy and frame completion: completion wins, so cmd_rdy=1 with the new values.
- TX path, FSM states IDLE -> LOAD -> SHIFT -> IDLE.
- send_resp in IDLE latches resp. The frame is start(0), 8 bits LSB first, stop(1), each bit BAUD_DIV cycles, for 10*BAUD_DIV cycles total.
- resp_sent pulses in the last cycle of the stop bit.
- send_resp while TX is busy is ignored; the in-flight byte is not corrupted.
- RX and TX are full duplex and independent.
- Reset mid-operation: next cycle TX=1, all state is cleared, and any partial frame is dropped.

Optional Feature:
FRAME_TIMEOUT_EN
- Defined: a gap counter runs while the byte index is non-zero. If it exceeds TIMEOUT_BITS*BAUD_DIV cycles with RX idle, the index resets to 0, shadow bytes are discarded, and frm_err pulses once.
- Undefined: no gap counter. A partial frame waits indefinitely for its remaining bytes.

Test Plan:
- Host sends 0x05,0x00,0xFF -> cmd_rdy rises about 1 cycle after the 3rd stop-bit sample; cmd=0x05, data=0x00FF. Pulse clr_cmd_rdy -> cmd_rdy=0 next cycle, cmd/data hold.
- send_resp with resp=0xA5 -> TX low for 2604 cycles, then bits 1,0,1,0,0,1,0,1, then high. resp_sent pulses at cycle 26040.
- Back-to-back frames 0x02,0x00,0x50 then 0x03,0xFF,0x80 with no clr -> cmd_rdy drops after the 2nd frame's byte0, then cmd=0x03, data=0xFF80.
- Byte with stop bit forced 0 after byte1 -> frm_err pulse, no cmd_rdy. A subsequent clean 0x08,0x00,0x00 frame -> cmd=0x08, data=0x0000.
- send_resp reasserted mid-transmission with resp=0x11 -> TX still carries 0xA5, only one resp_sent.
- rst asserted during byte1 reception, then 0x07,0x00,0x00 sent -> cmd=0x07, no stale bytes.
- With FRAME_TIMEOUT_EN: 0x04, then a 40-bit-time gap, then 0x06,0x00,0x00 -> frm_err pulse, cmd=0x06, data=0x0000.
